mem_copy_engine: RTL and testbench

- Bus-master copy engine directly upstream of the Memory block.
- Drives Memory's address, en and load inputs and the shared 16-bit data bus to copy a block of words from a source address range to a destination address range.
- Each word is copied with one read cycle (Memory drives the bus) followed by one write cycle (the engine drives the bus).
- Requests the bus from the CPU control logic and only acts while granted.

---
 rtl/mem_copy_engine_if.sv | 35 +++
 rtl/mem_copy_engine.sv | 100 ++++++++++
 tb/tb_mem_copy_engine.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_engine_if.sv
// Signal bundle between the copy engine and its host/Memory/bus environment.
// master = the copy engine, slave = the surrounding system.
interface mem_copy_engine_if #(
   parameter int WIDTH  = 16,
   parameter int AWIDTH = 16
);
   logic              start;
   logic [AWIDTH-1:0] src;
   logic [AWIDTH-1:0] dst;
   logic [AWIDTH-1:0] len;
   logic              abort;
   logic              bus_gnt;
   logic              bus_req;
   logic              busy;
   logic              done;
   logic [AWIDTH-1:0] remaining;
   logic [AWIDTH-1:0] mem_address;
   logic              mem_en;
   logic              mem_load;
   logic [WIDTH-1:0]  bus_in;
   logic [WIDTH-1:0]  bus_out;
   logic              bus_oe;

   modport master (
      input  start, src, dst, len, abort, bus_gnt, bus_in,
      output bus_req, busy, done, remaining,
      output mem_address, mem_en, mem_load, bus_out, bus_oe
   );

   modport slave (
      output start, src, dst, len, abort, bus_gnt, bus_in,
      input  bus_req, busy, done, remaining,
      input  mem_address, mem_en, mem_load, bus_out, bus_oe
   );
endinterface

// File: rtl/mem_copy_engine.sv
// Bus-master block copy engine: one read cycle then one write cycle per word,
// ascending addresses modulo 2^AWIDTH, acting only while the bus is granted.
module mem_copy_engine #(
   parameter int WIDTH  = 16,
   parameter int AWIDTH = 16
) (
   input logic clk,
   input logic reset,
   mem_copy_engine_if.master bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [AWIDTH-1:0] A_ONE = AWIDTH'(1);

   logic [1:0]        state;
   logic [AWIDTH-1:0] src_cur;
   logic [AWIDTH-1:0] dst_cur;
   logic [AWIDTH-1:0] remaining_q;
   logic [WIDTH-1:0]  data_q;
   logic              abort_pend;

   logic in_read;
   logic in_write;
   logic stop_now;

   assign in_read  = (state == READ);
   assign in_write = (state == WRITE);

   // An abort seen at any point in the word is remembered so that it still
   // ends the transfer at the WRITE exit even if the pulse has gone by then.
   assign stop_now = (remaining_q == A_ONE) || bus.abort || abort_pend;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         src_cur     <= '0;
         dst_cur     <= '0;
         remaining_q <= '0;
         data_q      <= '0;
         abort_pend  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               abort_pend <= 1'b0;
               if (bus.start) begin
                  src_cur     <= bus.src;
                  dst_cur     <= bus.dst;
                  remaining_q <= bus.len;
                  state       <= (bus.len == '0) ? DONE : READ;
               end
            end
            READ: begin
               if (bus.abort)
                  abort_pend <= 1'b1;
               if (bus.bus_gnt) begin
                  data_q <= bus.bus_in;
                  state  <= WRITE;
               end
            end
            WRITE: begin
               if (bus.abort)
                  abort_pend <= 1'b1;
               if (bus.bus_gnt) begin
                  src_cur     <= src_cur + A_ONE;
                  dst_cur     <= dst_cur + A_ONE;
                  remaining_q <= remaining_q - A_ONE;
                  state       <= stop_now ? DONE : READ;
               end
            end
            DONE: begin
               abort_pend <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode the state directly, so an asynchronous reset clears them
   // without waiting for a clock edge.
   assign bus.bus_req     = in_read | in_write;
   assign bus.busy        = in_read | in_write;
   assign bus.done        = (state == DONE);
   assign bus.remaining   = remaining_q;
   assign bus.mem_address = in_write ? dst_cur : src_cur;
   assign bus.mem_en      = in_read & bus.bus_gnt;
   assign bus.mem_load    = in_write & bus.bus_gnt;
   assign bus.bus_oe      = in_write & bus.bus_gnt;
   assign bus.bus_out     = data_q;

   a_no_conflict : assert property (@(posedge clk) disable iff (reset)
      !(bus.mem_en && bus.mem_load));
   a_oe_is_load : assert property (@(posedge clk) disable iff (reset)
      bus.bus_oe == bus.mem_load);
   a_quiet_without_gnt : assert property (@(posedge clk) disable iff (reset)
      !bus.bus_gnt |-> !(bus.mem_en || bus.mem_load || bus.bus_oe));
endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized bench for mem_copy_engine against a word-by-word copy model.
module tb_mem_copy_engine;
   localparam int W  = 16;
   localparam int AW = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_copy_engine_if #(.WIDTH(W), .AWIDTH(AW)) bus_if ();

   mem_copy_engine #(.WIDTH(W), .AWIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.master)
   );

   logic [W-1:0] ram  [0:65535];
   logic [W-1:0] mref [0:65535];

   int checks   = 0;
   int failures = 0;

   // Memory: drives the bus on en, captures the bus on load.
   always_comb begin
      bus_if.bus_in = '0;
      if (bus_if.mem_en)
         bus_if.bus_in = ram[bus_if.mem_address];
      else if (bus_if.bus_oe)
         bus_if.bus_in = bus_if.bus_out;
   end

   always @(posedge clk)
      if (bus_if.mem_load)
         ram[bus_if.mem_address] = bus_if.bus_out;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string pfx);
      check_eq({pfx, "_bus_req"}, bus_if.bus_req, 0);
      check_eq({pfx, "_busy"}, bus_if.busy, 0);
      check_eq({pfx, "_done"}, bus_if.done, 0);
      check_eq({pfx, "_mem_en"}, bus_if.mem_en, 0);
      check_eq({pfx, "_mem_load"}, bus_if.mem_load, 0);
      check_eq({pfx, "_bus_oe"}, bus_if.bus_oe, 0);
      check_eq({pfx, "_remaining"}, bus_if.remaining, 0);
      check_eq({pfx, "_mem_address"}, bus_if.mem_address, 0);
      check_eq({pfx, "_bus_out"}, bus_if.bus_out, 0);
   endtask

   task automatic compare_mem();
      int bad = 0;
      for (int i = 0; i < 65536; i++)
         if (ram[i] !== mref[i]) bad++;
      check_eq("ram_image", bad, 0);
   endtask

   // gmode: 0 = continuous grant, 1 = random grant, 2 = 3-cycle stall in first WRITE.
   // abort_w: word index whose READ carries an abort pulse (-1 none).
   // rst_at: granted-phase index at which reset is pulsed mid-cycle (-1 none).
   task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                           input int gmode, input int abort_w, input int rst_at);
      int target, gcount, w, stall_left, exp_lat;
      bit rd, g, ab_sent, finished;
      logic [15:0] ra, wa;
      target  = (abort_w >= 0 && abort_w < int'(n)) ? abort_w + 1 : int'(n);
      exp_lat = 2 * target + 1 + ((gmode == 2 && target > 0) ? 3 : 0);
      gcount = 0; stall_left = 3; ab_sent = 0; finished = 0;

      @(posedge clk); #1;
      bus_if.start = 1'b1; bus_if.src = s; bus_if.dst = d; bus_if.len = n;
      bus_if.abort = 1'b0; bus_if.bus_gnt = 1'($urandom);
      #2;
      check_eq("idle_busy", bus_if.busy, 0);
      check_eq("idle_bus_req", bus_if.bus_req, 0);
      check_eq("idle_mem_en", bus_if.mem_en, 0);

      for (int cyc = 1; cyc < 600; cyc++) begin
         @(posedge clk); #1;
         bus_if.start = 1'($urandom);
         bus_if.src   = 16'($urandom);
         bus_if.len   = 16'($urandom);
         if (gcount == 2 * target) begin
            bus_if.bus_gnt = 1'($urandom);
            bus_if.abort   = 1'($urandom);
            #2;
            check_eq("done_pulse", bus_if.done, 1);
            check_eq("done_busy", bus_if.busy, 0);
            check_eq("done_bus_req", bus_if.bus_req, 0);
            check_eq("done_mem_ctl", {bus_if.mem_en, bus_if.mem_load, bus_if.bus_oe}, 0);
            check_eq("done_remaining", bus_if.remaining, 32'(n) - 32'(target));
            if (gmode != 1) check_eq("latency", cyc, exp_lat);
            finished = 1;
            break;
         end
         rd = (gcount % 2 == 0);
         w  = gcount / 2;
         g  = (gmode == 1) ? ($urandom % 4 != 0) : 1'b1;
         if (gmode == 2 && gcount == 1 && stall_left > 0) begin
            g = 1'b0;
            stall_left--;
         end
         if (rst_at == gcount) g = 1'b1;
         bus_if.bus_gnt = g;
         bus_if.abort   = (rd && w == abort_w && !ab_sent);
         if (bus_if.abort) ab_sent = 1;
         ra = s + 16'(w);
         wa = d + 16'(w);
         #2;
         check_eq("xfer_bus_req", bus_if.bus_req, 1);
         check_eq("xfer_busy", bus_if.busy, 1);
         check_eq("xfer_done", bus_if.done, 0);
         check_eq("mem_en", bus_if.mem_en, g && rd);
         check_eq("mem_load", bus_if.mem_load, g && !rd);
         check_eq("bus_oe", bus_if.bus_oe, g && !rd);
         check_eq("mem_address", bus_if.mem_address, rd ? ra : wa);
         check_eq("remaining", bus_if.remaining, 32'(n) - 32'(w));
         if (!rd) check_eq("bus_out", bus_if.bus_out, mref[ra]);
         if (rst_at == gcount) begin
            #1 reset = 1'b1;
            #1 check_all_zero("rst_mid");
            #1 reset = 1'b0;
            bus_if.start = 1'b0;
            return;
         end
         if (g) begin
            if (!rd) mref[wa] = mref[ra];
            gcount++;
         end
      end
      check_eq("done_seen", finished, 1);
      @(posedge clk); #1;
      bus_if.start = 1'b0; bus_if.abort = 1'b0;
      #2;
      check_eq("post_done", bus_if.done, 0);
      check_eq("post_busy", bus_if.busy, 0);
   endtask

   initial begin
      logic [15:0] s, d, n;
      int ab;
      reset = 1'b1;
      bus_if.start = 1'b0; bus_if.src = '0; bus_if.dst = '0; bus_if.len = '0;
      bus_if.abort = 1'b0; bus_if.bus_gnt = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         ram[i]  = 16'($urandom);
         mref[i] = ram[i];
      end
      for (int i = 0; i < 4; i++) begin
         ram[16'h1000 + i]  = 16'hA0 + 16'(i);
         mref[16'h1000 + i] = 16'hA0 + 16'(i);
      end
      #12;
      check_all_zero("reset");
      @(negedge clk) reset = 1'b0;

      run_copy(16'h1000, 16'h2000, 16'd4, 0, -1, -1);
      compare_mem();
      for (int i = 0; i < 4; i++)
         check_eq("single_word", ram[16'h2000 + i], 16'hA0 + 16'(i));

      run_copy(16'h4000, 16'h5000, 16'd0, 0, -1, -1);
      compare_mem();

      run_copy(16'h1100, 16'h2100, 16'd2, 2, -1, -1);
      compare_mem();

      run_copy(16'hFFFE, 16'h3000, 16'd4, 0, -1, -1);
      compare_mem();
      check_eq("wrap_rom0", ram[16'h3002], ram[16'h0000]);
      check_eq("wrap_rom1", ram[16'h3003], ram[16'h0001]);

      run_copy(16'h6000, 16'h7000, 16'd10, 0, 2, -1);
      compare_mem();

      run_copy(16'h8000, 16'h9000, 16'd5, 0, -1, 3);
      compare_mem();
      run_copy(16'h8000, 16'hA000, 16'd3, 0, -1, -1);
      compare_mem();

      run_copy(16'hB000, 16'hB002, 16'd6, 1, -1, -1);
      compare_mem();

      for (int t = 0; t < 25; t++) begin
         s = 16'($urandom);
         d = ($urandom % 2 == 0) ? s + 16'($urandom_range(1, 5)) : 16'($urandom);
         n = 16'($urandom_range(0, 12));
         ab = ($urandom % 3 == 0) ? int'($urandom_range(0, 11)) : -1;
         run_copy(s, d, n, 1, ab, -1);
         compare_mem();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
